// File: rtl/augment_pkg.sv
// Shared definitions for the blur ping-pong buffer controller.
//   slot_state_t       : lifecycle of one image slot in the shared BRAM
//   DEFAULT_SLOT1_BASE : default base address of image slot 1 (slot 0 is at 0)
package augment_pkg;

  typedef enum logic [1:0] {
    SLOT_EMPTY   = 2'd0,
    SLOT_FILLING = 2'd1,
    SLOT_FULL    = 2'd2,
    SLOT_READING = 2'd3
  } slot_state_t;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 11;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam logic [10:0] DEFAULT_SLOT1_BASE = 11'd784;

endpackage

// File: rtl/blur_pingpong_ctrl_if.sv
// Bundle of writer, reader, BRAM and debug signals for blur_pingpong_ctrl.
//   writer : wr_addr, wr_data, wr_en, wr_image_done -> wr_slot, wr_stall
//   reader : rd_ack, rd_release, rd_req, rd_addr -> rd_ready, rd_slot, rd_base,
//            rd_gnt, rd_data, rd_data_valid
//   bram   : bram_dout -> bram_addr, bram_din, bram_we (1-cycle read latency)
//   debug  : slot0_state, slot1_state (current state of each slot FSM)
// Handshakes: a slot is claimed when rd_ack is high in a cycle where rd_ready
// is high, and a read is accepted when rd_req is high in a cycle where rd_gnt
// is high; rd_data_valid follows an accepted read by exactly one cycle.
// rd_ack/rd_release/wr_image_done presented without their qualifying condition
// are dropped, never queued.
// Modports: master = writer/reader/BRAM side, slave = controller.
interface blur_pingpong_ctrl_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
);
  import augment_pkg::*;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  wr_image_done;
  logic                  wr_slot;
  logic                  wr_stall;

  logic                  rd_ready;
  logic                  rd_slot;
  logic [ADDR_WIDTH-1:0] rd_base;
  logic                  rd_ack;
  logic                  rd_release;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;

  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din;
  logic                  bram_we;
  logic [DATA_WIDTH-1:0] bram_dout;

  slot_state_t           slot0_state;
  slot_state_t           slot1_state;

  modport master (
    output wr_addr, wr_data, wr_en, wr_image_done,
    output rd_ack, rd_release, rd_req, rd_addr,
    output bram_dout,
    input  wr_slot, wr_stall,
    input  rd_ready, rd_slot, rd_base, rd_gnt, rd_data, rd_data_valid,
    input  bram_addr, bram_din, bram_we,
    input  slot0_state, slot1_state
  );

  modport slave (
    input  wr_addr, wr_data, wr_en, wr_image_done,
    input  rd_ack, rd_release, rd_req, rd_addr,
    input  bram_dout,
    output wr_slot, wr_stall,
    output rd_ready, rd_slot, rd_base, rd_gnt, rd_data, rd_data_valid,
    output bram_addr, bram_din, bram_we,
    output slot0_state, slot1_state
  );

endinterface

// File: rtl/slot_fsm.sv
// State machine for one image slot: EMPTY -> FILLING -> FULL -> READING -> EMPTY.
//   clk, reset  : clock, asynchronous active-high reset (to RESET_STATE)
//   fill_start  : writer is pointing at this slot (taken only from EMPTY)
//   fill_done   : writer finished this slot (taken from EMPTY or FILLING)
//   claim       : reader claimed this slot (taken only from FULL)
//   free        : reader released this slot (taken only from READING)
//   state       : current slot state
module slot_fsm import augment_pkg::*; #(
  parameter slot_state_t RESET_STATE = SLOT_EMPTY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fill_start,
  input  logic        fill_done,
  input  logic        claim,
  input  logic        free,
  output slot_state_t state
);

  slot_state_t state_q;
  slot_state_t state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      // A done pulse can land before the EMPTY->FILLING step has happened,
      // so EMPTY also accepts it and goes straight to FULL.
      SLOT_EMPTY:   if (fill_done) state_d = SLOT_FULL;
                    else if (fill_start) state_d = SLOT_FILLING;
      SLOT_FILLING: if (fill_done) state_d = SLOT_FULL;
      SLOT_FULL:    if (claim) state_d = SLOT_READING;
      SLOT_READING: if (free) state_d = SLOT_EMPTY;
      default:      state_d = SLOT_EMPTY;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/blur_pingpong_ctrl.sv
// Ping-pong controller sharing one BRAM between an image writer and a reader.
// Two slot FSMs track the image slots; the writer fills wr_slot, the reader
// walks slots 0,1,0,... via its pointer (rd_slot). BRAM access is arbitrated
// combinationally with the writer taking priority.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : blur_pingpong_ctrl_if slave (writer, reader, BRAM, debug)
module blur_pingpong_ctrl import augment_pkg::*; #(
  parameter int unsigned           ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] SLOT1_BASE = ADDR_WIDTH'(DEFAULT_SLOT1_BASE)
) (
  input logic                 clk,
  input logic                 reset,
  blur_pingpong_ctrl_if.slave bus
);

  slot_state_t slot0_state, slot1_state, wr_state, ptr_state;
  logic        wr_slot_q, ptr_q, rd_valid_q;
  logic        wr_slot_next, done_eff, ack_eff, release_eff;
  logic        any_reading, stall, ready, gnt;
  logic [1:0]  fill_start, fill_done, claim, free;

  always_comb begin
    wr_state    = wr_slot_q ? slot1_state : slot0_state;
    ptr_state   = ptr_q ? slot1_state : slot0_state;
    any_reading = (slot0_state == SLOT_READING) || (slot1_state == SLOT_READING);
    stall       = !((wr_state == SLOT_EMPTY) || (wr_state == SLOT_FILLING));
    ready       = (ptr_state == SLOT_FULL) && !any_reading;
    done_eff    = bus.wr_image_done && !stall;
    ack_eff     = bus.rd_ack && ready;
    release_eff = bus.rd_release && any_reading;
    wr_slot_next = wr_slot_q ^ done_eff;
    // The writer's next slot starts filling as soon as it is EMPTY; the FSM
    // ignores this while the slot is in any other state.
    fill_start  = {wr_slot_next, !wr_slot_next};
    fill_done   = done_eff ? {wr_slot_q, !wr_slot_q} : 2'b00;
    // Only the pointer slot can be claimed, and the pointer does not move
    // until release, so the READING slot is always the pointer slot.
    claim       = ack_eff ? {ptr_q, !ptr_q} : 2'b00;
    free        = release_eff ? {ptr_q, !ptr_q} : 2'b00;
    gnt         = !bus.wr_en && bus.rd_req && any_reading && !reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_slot_q  <= 1'b0;
      ptr_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_slot_q  <= wr_slot_next;
      ptr_q      <= ptr_q ^ release_eff;
      rd_valid_q <= gnt;
    end
  end

  slot_fsm #(.RESET_STATE(SLOT_FILLING)) u_slot0 (
    .clk        (clk),
    .reset      (reset),
    .fill_start (fill_start[0]),
    .fill_done  (fill_done[0]),
    .claim      (claim[0]),
    .free       (free[0]),
    .state      (slot0_state)
  );

  slot_fsm #(.RESET_STATE(SLOT_EMPTY)) u_slot1 (
    .clk        (clk),
    .reset      (reset),
    .fill_start (fill_start[1]),
    .fill_done  (fill_done[1]),
    .claim      (claim[1]),
    .free       (free[1]),
    .state      (slot1_state)
  );

  assign bus.wr_slot       = wr_slot_q;
  assign bus.wr_stall      = stall;
  assign bus.rd_ready      = ready;
  assign bus.rd_slot       = ptr_q;
  assign bus.rd_base       = ptr_q ? SLOT1_BASE : '0;
  assign bus.rd_gnt        = gnt;
  assign bus.rd_data       = DATA_WIDTH'(bus.bram_dout);
  assign bus.rd_data_valid = rd_valid_q;
  // Writes are blocked while reset is high even though reset is asynchronous.
  assign bus.bram_we       = bus.wr_en && !reset;
  assign bus.bram_addr     = bus.wr_en ? bus.wr_addr : bus.rd_addr;
  assign bus.bram_din      = bus.wr_data;
  assign bus.slot0_state   = slot0_state;
  assign bus.slot1_state   = slot1_state;

endmodule

// File: tb/tb_blur_pingpong_ctrl.sv
// Bench for blur_pingpong_ctrl: BRAM model, arbitration vector table,
// hand-written slot-sequencing scenarios and a read-data scoreboard.
module tb_blur_pingpong_ctrl;
  import augment_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks;
  int   errors;

  logic [7:0] bram    [2048];
  logic [7:0] ref_mem [2048];
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  typedef struct {
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_req;
    logic [10:0] rd_addr;
    logic        exp_we;
    logic        exp_gnt;
    logic        exp_valid;
    logic        chk_addr;
    logic [10:0] exp_addr;
  } arb_vec_t;

  arb_vec_t vecs [8];

  blur_pingpong_ctrl_if #(.ADDR_WIDTH(11), .DATA_WIDTH(8)) bus ();

  blur_pingpong_ctrl #(.ADDR_WIDTH(11), .DATA_WIDTH(8), .SLOT1_BASE(11'd784)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset-free clock generator
  always #5 clk = ~clk;

  // BRAM model, 1-cycle read latency
  always @(posedge clk) begin
    if (bus.bram_we) bram[bus.bram_addr] <= bus.bram_din;
    bus.bram_dout <= bram[bus.bram_addr];
  end

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_image_done = 1'b0;
    bus.rd_ack = 1'b0; bus.rd_release = 1'b0; bus.rd_req = 1'b0; bus.rd_addr = '0;
  endtask

  // scoreboard: pop the expected word whenever the DUT presents read data
  always @(negedge clk) begin
    if (!reset && bus.rd_data_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_data_unexpected: rd_data_valid=1, expected no read data");
      end else begin
        mon_exp = exp_q.pop_front();
        chk_val("rd_data_scoreboard", 32'(bus.rd_data), 32'(mon_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = '0;

    //            wr_en wr_addr  wr_data              rd_req rd_addr we   gnt  valid chkA addr
    vecs[0] = '{1'b1, 11'd784, 8'hA5,               1'b1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd784};
    vecs[1] = '{1'b0, 11'd0,   8'h00,               1'b1, 11'd0, 1'b0, 1'b1, 1'b0, 1'b1, 11'd0};
    vecs[2] = '{1'b1, 11'd785, 8'($urandom_range(0, 255)), 1'b0, 11'd0, 1'b1, 1'b0, 1'b1, 1'b1, 11'd785};
    vecs[3] = '{1'b0, 11'd0,   8'h00,               1'b1, 11'd1, 1'b0, 1'b1, 1'b0, 1'b1, 11'd1};
    vecs[4] = '{1'b0, 11'd0,   8'h00,               1'b1, 11'd2, 1'b0, 1'b1, 1'b1, 1'b1, 11'd2};
    vecs[5] = '{1'b0, 11'd0,   8'h00,               1'b0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd0};
    vecs[6] = '{1'b1, 11'd786, 8'($urandom_range(0, 255)), 1'b1, 11'd3, 1'b1, 1'b0, 1'b0, 1'b1, 11'd786};
    vecs[7] = '{1'b0, 11'd0,   8'h00,               1'b1, 11'd3, 1'b0, 1'b1, 1'b0, 1'b1, 11'd3};

    // reset with every input active: nothing may leak through
    reset = 1'b1;
    drive_idle();
    bus.wr_en = 1'b1; bus.wr_addr = 11'd9; bus.wr_data = 8'h77;
    bus.rd_req = 1'b1; bus.rd_ack = 1'b1; bus.wr_image_done = 1'b1;
    @(negedge clk);
    chk_val("reset_bram_we", 32'(bus.bram_we), 32'd0);
    chk_val("reset_rd_gnt", 32'(bus.rd_gnt), 32'd0);
    chk_val("reset_rd_data_valid", 32'(bus.rd_data_valid), 32'd0);
    chk_val("reset_wr_stall", 32'(bus.wr_stall), 32'd0);
    chk_val("reset_rd_ready", 32'(bus.rd_ready), 32'd0);
    chk_val("reset_wr_slot", 32'(bus.wr_slot), 32'd0);
    chk_val("reset_rd_slot", 32'(bus.rd_slot), 32'd0);
    chk_val("reset_slot0", 32'(bus.slot0_state), 32'(SLOT_FILLING));
    chk_val("reset_slot1", 32'(bus.slot1_state), 32'(SLOT_EMPTY));
    tick();
    tick();
    reset = 1'b0;
    drive_idle();

    // rd_ack and rd_req with nothing full or reading are dropped
    bus.rd_ack = 1'b1; bus.rd_req = 1'b1; bus.rd_addr = 11'd0;
    @(negedge clk);
    chk_val("idle_rd_ready", 32'(bus.rd_ready), 32'd0);
    chk_val("idle_rd_gnt", 32'(bus.rd_gnt), 32'd0);
    tick();
    drive_idle();
    @(negedge clk);
    chk_val("ack_ignored_slot0", 32'(bus.slot0_state), 32'(SLOT_FILLING));
    chk_val("ack_ignored_slot1", 32'(bus.slot1_state), 32'(SLOT_EMPTY));
    chk_val("idle_rd_data_valid", 32'(bus.rd_data_valid), 32'd0);
    tick();

    // fill slot 0 and finish it
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_addr = 11'(i);
      bus.wr_data = 8'($urandom_range(0, 255));
      ref_mem[i] = bus.wr_data;
      tick();
    end
    drive_idle();
    bus.wr_image_done = 1'b1;
    tick();
    drive_idle();
    @(negedge clk);
    chk_val("fill0_wr_slot", 32'(bus.wr_slot), 32'd1);
    chk_val("fill0_rd_ready", 32'(bus.rd_ready), 32'd1);
    chk_val("fill0_rd_slot", 32'(bus.rd_slot), 32'd0);
    chk_val("fill0_rd_base", 32'(bus.rd_base), 32'd0);
    chk_val("fill0_wr_stall", 32'(bus.wr_stall), 32'd0);
    chk_val("fill0_slot0", 32'(bus.slot0_state), 32'(SLOT_FULL));
    chk_val("fill0_slot1", 32'(bus.slot1_state), 32'(SLOT_FILLING));
    tick();

    // claim slot 0; a read in the claim cycle is not yet granted
    bus.rd_ack = 1'b1; bus.rd_req = 1'b1; bus.rd_addr = 11'd0;
    @(negedge clk);
    chk_val("claim_cycle_rd_gnt", 32'(bus.rd_gnt), 32'd0);
    tick();
    drive_idle();
    @(negedge clk);
    chk_val("claim_slot0", 32'(bus.slot0_state), 32'(SLOT_READING));
    chk_val("claim_rd_ready", 32'(bus.rd_ready), 32'd0);
    tick();

    // arbitration vectors while slot 0 is READING
    for (int k = 0; k < 8; k++) begin
      bus.wr_en = vecs[k].wr_en; bus.wr_addr = vecs[k].wr_addr; bus.wr_data = vecs[k].wr_data;
      bus.rd_req = vecs[k].rd_req; bus.rd_addr = vecs[k].rd_addr;
      @(negedge clk);
      chk_val($sformatf("vec%0d_bram_we", k), 32'(bus.bram_we), 32'(vecs[k].exp_we));
      chk_val($sformatf("vec%0d_rd_gnt", k), 32'(bus.rd_gnt), 32'(vecs[k].exp_gnt));
      chk_val($sformatf("vec%0d_rd_data_valid", k), 32'(bus.rd_data_valid), 32'(vecs[k].exp_valid));
      if (vecs[k].chk_addr)
        chk_val($sformatf("vec%0d_bram_addr", k), 32'(bus.bram_addr), 32'(vecs[k].exp_addr));
      if (vecs[k].wr_en)
        chk_val($sformatf("vec%0d_bram_din", k), 32'(bus.bram_din), 32'(vecs[k].wr_data));
      if (vecs[k].exp_gnt) exp_q.push_back(ref_mem[vecs[k].rd_addr]);
      if (vecs[k].wr_en) ref_mem[vecs[k].wr_addr] = vecs[k].wr_data;
      tick();
    end
    drive_idle();

    // finish slot 1 while slot 0 is still being read -> writer stalls
    bus.wr_image_done = 1'b1;
    tick();
    drive_idle();
    @(negedge clk);
    chk_val("fill1_wr_slot", 32'(bus.wr_slot), 32'd0);
    chk_val("fill1_wr_stall", 32'(bus.wr_stall), 32'd1);
    chk_val("fill1_slot1", 32'(bus.slot1_state), 32'(SLOT_FULL));
    chk_val("fill1_rd_ready", 32'(bus.rd_ready), 32'd0);
    tick();

    // done while stalled is ignored
    bus.wr_image_done = 1'b1;
    tick();
    drive_idle();
    @(negedge clk);
    chk_val("stalled_done_wr_slot", 32'(bus.wr_slot), 32'd0);
    chk_val("stalled_done_slot0", 32'(bus.slot0_state), 32'(SLOT_READING));
    tick();

    // release slot 0 -> stall clears, pointer moves to slot 1
    bus.rd_release = 1'b1;
    tick();
    drive_idle();
    @(negedge clk);
    chk_val("rel0_slot0", 32'(bus.slot0_state), 32'(SLOT_EMPTY));
    chk_val("rel0_wr_stall", 32'(bus.wr_stall), 32'd0);
    chk_val("rel0_rd_slot", 32'(bus.rd_slot), 32'd1);
    chk_val("rel0_rd_base", 32'(bus.rd_base), 32'd784);
    chk_val("rel0_rd_ready", 32'(bus.rd_ready), 32'd1);
    tick();
    @(negedge clk);
    chk_val("rel0_slot0_refill", 32'(bus.slot0_state), 32'(SLOT_FILLING));
    tick();

    // claim slot 1 and read back the word written at 784
    bus.rd_ack = 1'b1;
    tick();
    drive_idle();
    @(negedge clk);
    chk_val("claim1_slot1", 32'(bus.slot1_state), 32'(SLOT_READING));
    tick();
    bus.rd_req = 1'b1; bus.rd_addr = 11'd784;
    @(negedge clk);
    chk_val("read784_rd_gnt", 32'(bus.rd_gnt), 32'd1);
    exp_q.push_back(ref_mem[784]);
    tick();
    drive_idle();
    @(negedge clk);
    chk_val("read784_valid", 32'(bus.rd_data_valid), 32'd1);
    chk_val("read784_data", 32'(bus.rd_data), 32'h0000_00A5);
    tick();

    // finish slot 0 while slot 1 is READING -> stalled, then reset mid-cycle
    bus.wr_image_done = 1'b1;
    tick();
    drive_idle();
    @(negedge clk);
    chk_val("pre_reset_wr_stall", 32'(bus.wr_stall), 32'd1);
    chk_val("pre_reset_wr_slot", 32'(bus.wr_slot), 32'd1);
    bus.wr_en = 1'b1; bus.wr_addr = 11'd5; bus.wr_data = 8'hEE;
    bus.rd_req = 1'b1; bus.rd_addr = 11'd784;
    reset = 1'b1;
    #1;
    chk_val("midrst_wr_stall", 32'(bus.wr_stall), 32'd0);
    chk_val("midrst_rd_ready", 32'(bus.rd_ready), 32'd0);
    chk_val("midrst_rd_gnt", 32'(bus.rd_gnt), 32'd0);
    chk_val("midrst_bram_we", 32'(bus.bram_we), 32'd0);
    chk_val("midrst_rd_data_valid", 32'(bus.rd_data_valid), 32'd0);
    chk_val("midrst_wr_slot", 32'(bus.wr_slot), 32'd0);
    chk_val("midrst_rd_slot", 32'(bus.rd_slot), 32'd0);
    chk_val("midrst_slot0", 32'(bus.slot0_state), 32'(SLOT_FILLING));
    chk_val("midrst_slot1", 32'(bus.slot1_state), 32'(SLOT_EMPTY));
    tick();
    tick();
    reset = 1'b0;
    drive_idle();

    // fill both slots without a claim -> stall; claim+release slot 0 clears it
    bus.wr_image_done = 1'b1;
    tick();
    tick();
    drive_idle();
    @(negedge clk);
    chk_val("both_full_wr_stall", 32'(bus.wr_stall), 32'd1);
    chk_val("both_full_wr_slot", 32'(bus.wr_slot), 32'd0);
    chk_val("both_full_rd_slot", 32'(bus.rd_slot), 32'd0);
    tick();
    bus.rd_ack = 1'b1;
    tick();
    drive_idle();
    bus.rd_release = 1'b1;
    @(negedge clk);
    chk_val("release_cycle_wr_stall", 32'(bus.wr_stall), 32'd1);
    tick();
    drive_idle();
    @(negedge clk);
    chk_val("after_release_wr_stall", 32'(bus.wr_stall), 32'd0);
    chk_val("after_release_wr_slot", 32'(bus.wr_slot), 32'd0);
    tick();

    // same-cycle done on slot 1 and release of slot 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive_idle();
    bus.wr_image_done = 1'b1;
    tick();
    drive_idle();
    bus.rd_ack = 1'b1;
    tick();
    drive_idle();
    bus.wr_image_done = 1'b1;
    bus.rd_release = 1'b1;
    tick();
    drive_idle();
    @(negedge clk);
    chk_val("cross_slot0", 32'(bus.slot0_state), 32'(SLOT_EMPTY));
    chk_val("cross_slot1", 32'(bus.slot1_state), 32'(SLOT_FULL));
    chk_val("cross_rd_ready", 32'(bus.rd_ready), 32'd1);
    chk_val("cross_rd_slot", 32'(bus.rd_slot), 32'd1);
    chk_val("cross_rd_base", 32'(bus.rd_base), 32'd784);
    chk_val("cross_wr_slot", 32'(bus.wr_slot), 32'd0);
    chk_val("cross_wr_stall", 32'(bus.wr_stall), 32'd0);

    repeat (3) tick();
    chk_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blur_pingpong_ctrl.md
BLUR_PINGPONG_CTRL -- requirements
Module: blur_pingpong_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 11, BRAM address bits; DATA_WIDTH, default 8, BRAM word bits; SLOT1_BASE, default 11'd784, base address of image slot 1 (slot 0 base is 0).
REQ-002 SHALL have ports: clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have writer ports: wr_addr  in  ADDR_WIDTH  writer address; wr_data  in  DATA_WIDTH  writer data; wr_en  in  1  writer write strobe; wr_image_done  in  1  one-cycle pulse, writer finished a slot.
REQ-004 SHALL have writer control outputs: wr_slot  out  1  slot the writer fills; wr_stall  out  1  writer must hold (no free slot).
REQ-005 SHALL have reader ports: rd_ready  out  1  a full slot is available; rd_slot  out  1  slot offered/held by reader; rd_base  out  ADDR_WIDTH  base of rd_slot; rd_ack  in  1  reader claims offered slot; rd_release  in  1  reader done with slot; rd_req  in  1  read request; rd_addr  in  ADDR_WIDTH  absolute read address; rd_gnt  out  1  request accepted this cycle; rd_data  out  DATA_WIDTH  read data; rd_data_valid  out  1  rd_data valid.
REQ-006 SHALL have BRAM port: bram_addr  out  ADDR_WIDTH; bram_din  out  DATA_WIDTH; bram_we  out  1; bram_dout  in  DATA_WIDTH (1-cycle read latency).

Function
REQ-007 SHALL track each slot in state EMPTY, FILLING, FULL or READING.
REQ-008 SHALL hold wr_slot's slot in FILLING while writer active; on wr_image_done it SHALL move that slot to FULL, toggle wr_slot next cycle, and mark the new slot FILLING if EMPTY.
REQ-009 SHALL assert wr_stall combinationally whenever wr_slot's slot is not EMPTY/FILLING; stall SHALL clear the cycle after that slot becomes EMPTY, which then becomes FILLING.
REQ-010 SHALL keep a reader pointer that alternates 0,1,0,...; rd_ready=1 iff pointer slot is FULL and no slot is READING.
REQ-011 On rd_ack while rd_ready, the pointer slot SHALL go READING; rd_ack without rd_ready SHALL be ignored.
REQ-012 On rd_release while a slot is READING, that slot SHALL go EMPTY and the pointer SHALL toggle; rd_release otherwise ignored.
REQ-013 wr_image_done and rd_release in the same cycle on different slots SHALL both take effect.
REQ-014 wr_image_done while wr_stall=1 SHALL be ignored.
REQ-015 BRAM arbitration: wr_en has priority; when wr_en=1, bram_addr=wr_addr, bram_din=wr_data, bram_we=1, rd_gnt=0.
REQ-016 When wr_en=0 and rd_req=1 and a slot is READING, bram_addr=rd_addr, bram_we=0, rd_gnt=1; rd_data_valid SHALL pulse exactly one cycle after rd_gnt with rd_data=bram_dout.
REQ-017 rd_req while no slot is READING SHALL not be granted.
REQ-018 rd_base SHALL be 0 for rd_slot=0 and SLOT1_BASE for rd_slot=1; rd_slot SHALL equal the reader pointer.
REQ-019 Arbitration outputs SHALL be combinational; rd_data_valid SHALL be registered.

Reset
REQ-020 On reset: slot 0 FILLING, slot 1 EMPTY, wr_slot=0, pointer=0, wr_stall=0, rd_ready=0, rd_data_valid=0, rd_gnt=0, bram_we=0.
REQ-021 Reset mid-operation SHALL discard all slot contents status and return to REQ-020 state; no BRAM write SHALL occur while reset is high.

Structure
REQ-022 Slot-state enum and default SLOT1_BASE SHALL live in shared package augment_pkg.
REQ-023 Per-slot state machine SHALL be one sub-module slot_fsm, instantiated twice; arbiter logic SHALL be in the top module.

Verification
REQ-024 Fill slot 0 (wr_image_done) -> next cycle wr_slot=1, rd_ready=1, rd_slot=0, rd_base=0.
REQ-025 Fill both slots without ack -> wr_stall=1; rd_ack then rd_release on slot 0 -> wr_stall=0 one cycle later, wr_slot=0.
REQ-026 wr_en=1 and rd_req=1 same cycle -> bram_we=1, rd_gnt=0; next cycle wr_en=0 -> rd_gnt=1, rd_data_valid=1 the following cycle with stored word.
REQ-027 Write 0xA5 to address 784, fill slot 1, read 784 after ack -> rd_data=0xA5.
REQ-028 Same-cycle wr_image_done (slot 1) and rd_release (slot 0) -> slot 0 EMPTY, slot 1 FULL, rd_ready=1 with rd_slot=1.
REQ-029 Assert reset while slot READING and stalled -> all outputs at REQ-020 values immediately.
